// File: rtl/execute_stage_pkg.sv
// execute_stage_pkg: shared execute constants,
// ALU/forward encodings and the E/M bundle.
package execute_stage_pkg;

  localparam int XLEN = 32;
  localparam int RLEN = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_RD = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_e;

  typedef struct packed {
    logic            regwrite;
    logic            memwrite;
    logic            resultsrc;
    logic [RLEN-1:0] rd;
    logic [XLEN-1:0] pcplus4;
    logic [XLEN-1:0] writedata;
    logic [XLEN-1:0] aluresult;
  } ex_mem_t;

  // select 11 falls back to the register file operand
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [1:0]      sel,
    input logic [XLEN-1:0] rd,
    input logic [XLEN-1:0] w,
    input logic [XLEN-1:0] m
  );
    case (sel)
      FWD_W:   return w;
      FWD_M:   return m;
      default: return rd;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// alu: combinational add/sub/and/or/slt
// with zero flag for branch resolution.
module alu
  import execute_stage_pkg::*;
(
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic [2:0]      ALUControl,
  output logic [XLEN-1:0] ALUResult,
  output logic            Zero
);

  logic lt;

  assign lt = $signed(SrcA) < $signed(SrcB);

  // operation select; unlisted codes yield zero
  always_comb begin
    ALUResult = '0;
    case (ALUControl)
      ALU_ADD: ALUResult = SrcA + SrcB;
      ALU_SUB: ALUResult = SrcA - SrcB;
      ALU_AND: ALUResult = SrcA & SrcB;
      ALU_OR:  ALUResult = SrcA | SrcB;
      ALU_SLT: ALUResult = {{(XLEN-1){1'b0}}, lt};
      default: ALUResult = '0;
    endcase
  end

  assign Zero = (ALUResult == '0);

endmodule

// File: rtl/execute_stage.sv
// execute_stage: forwarding, ALU, branch
// resolution and the E/M pipeline register.
module execute_stage
  import execute_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteE,
  input  logic            ALUSrcE,
  input  logic            MemWriteE,
  input  logic            ResultSrcE,
  input  logic            BranchE,
  input  logic [2:0]      ALUControlE,
  input  logic [XLEN-1:0] RD1E,
  input  logic [XLEN-1:0] RD2E,
  input  logic [XLEN-1:0] ImmExtE,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [RLEN-1:0] RDE,
  input  logic [XLEN-1:0] ResultW,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic            ResultSrcM,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [RLEN-1:0] RDM
);

  logic [XLEN-1:0] srca;
  logic [XLEN-1:0] srcb;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] aluresult;
  logic            zero;
  ex_mem_t         em;

  assign srca  = fwd_sel(ForwardAE, RD1E, ResultW, em.aluresult);
  assign wdata = fwd_sel(ForwardBE, RD2E, ResultW, em.aluresult);
  assign srcb  = ALUSrcE ? ImmExtE : wdata;

  alu u_alu (
    .SrcA       (srca),
    .SrcB       (srcb),
    .ALUControl (ALUControlE),
    .ALUResult  (aluresult),
    .Zero       (zero)
  );

  assign PCSrcE    = BranchE & zero;
  assign PCTargetE = PCE + ImmExtE;

  // E/M register: captures every edge, cleared by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      em <= '0;
    end else begin
      em.regwrite  <= RegWriteE;
      em.memwrite  <= MemWriteE;
      em.resultsrc <= ResultSrcE;
      em.rd        <= RDE;
      em.pcplus4   <= PCPlus4E;
      em.writedata <= wdata;
      em.aluresult <= aluresult;
    end
  end

  assign RegWriteM  = em.regwrite;
  assign MemWriteM  = em.memwrite;
  assign ResultSrcM = em.resultsrc;
  assign RDM        = em.rd;
  assign PCPlus4M   = em.pcplus4;
  assign WriteDataM = em.writedata;
  assign ALUResultM = em.aluresult;

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed vectors
// against hand-computed results.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteE, ALUSrcE, MemWriteE;
  logic        ResultSrcE, BranchE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  RDE;
  logic [31:0] ResultW;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, MemWriteM, ResultSrcM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RDM;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  execute_stage dut (
    .clk         (clk),
    .rst         (rst),
    .RegWriteE   (RegWriteE),
    .ALUSrcE     (ALUSrcE),
    .MemWriteE   (MemWriteE),
    .ResultSrcE  (ResultSrcE),
    .BranchE     (BranchE),
    .ALUControlE (ALUControlE),
    .RD1E        (RD1E),
    .RD2E        (RD2E),
    .ImmExtE     (ImmExtE),
    .PCE         (PCE),
    .PCPlus4E    (PCPlus4E),
    .RDE         (RDE),
    .ResultW     (ResultW),
    .ForwardAE   (ForwardAE),
    .ForwardBE   (ForwardBE),
    .PCSrcE      (PCSrcE),
    .PCTargetE   (PCTargetE),
    .RegWriteM   (RegWriteM),
    .MemWriteM   (MemWriteM),
    .ResultSrcM  (ResultSrcM),
    .ALUResultM  (ALUResultM),
    .WriteDataM  (WriteDataM),
    .PCPlus4M    (PCPlus4M),
    .RDM         (RDM)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [2:0] alu,
                    input logic [31:0] a,
                    input logic [31:0] b);
    ALUControlE = alu;
    RD1E = a;
    RD2E = b;
    ALUSrcE = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    BranchE = 1'b0;
  endtask

  task automatic zero_m(input string tag);
    chk({tag, "_rw"},  {31'd0, RegWriteM}, 0);
    chk({tag, "_mw"},  {31'd0, MemWriteM}, 0);
    chk({tag, "_rs"},  {31'd0, ResultSrcM}, 0);
    chk({tag, "_alu"}, ALUResultM, 0);
    chk({tag, "_wd"},  WriteDataM, 0);
    chk({tag, "_pc4"}, PCPlus4M, 0);
    chk({tag, "_rd"},  {27'd0, RDM}, 0);
  endtask

  initial begin
    rst = 1'b0;
    RegWriteE = $urandom;
    ALUSrcE = $urandom;
    MemWriteE = $urandom;
    ResultSrcE = $urandom;
    BranchE = $urandom;
    ALUControlE = $urandom;
    RD1E = $urandom;
    RD2E = $urandom;
    ImmExtE = $urandom;
    PCE = $urandom;
    PCPlus4E = $urandom;
    RDE = $urandom;
    ResultW = $urandom;
    ForwardAE = $urandom;
    ForwardBE = $urandom;
    #3;
    zero_m("rst_async");
    tick();
    tick();
    zero_m("rst_hold");

    // first capture after release
    RegWriteE = 1'b1;
    MemWriteE = 1'b0;
    ResultSrcE = 1'b0;
    op(3'b000, 32'd5, 32'd7);
    RDE = 5'd3;
    PCPlus4E = 32'h104;
    ResultW = 32'h0;
    ImmExtE = 32'h0;
    PCE = 32'h100;
    #2 rst = 1'b1;
    tick();
    chk("first_alu", ALUResultM, 32'd12);
    chk("first_rd", {27'd0, RDM}, 32'd3);
    chk("first_rw", {31'd0, RegWriteM}, 32'd1);
    chk("first_wd", WriteDataM, 32'd7);
    chk("first_pc4", PCPlus4M, 32'h104);

    // branch taken / not taken
    op(3'b001, 32'd9, 32'd9);
    BranchE = 1'b1;
    PCE = 32'h100;
    ImmExtE = 32'hFFFF_FFF0;
    #1;
    chk("beq_taken", {31'd0, PCSrcE}, 32'd1);
    chk("beq_target", PCTargetE, 32'hF0);
    RD2E = 32'd8;
    #1;
    chk("beq_not", {31'd0, PCSrcE}, 32'd0);
    tick();
    chk("beq_alu", ALUResultM, 32'd1);

    // forwarding from M and W
    op(3'b000, 32'h20, 32'h0);
    tick();
    chk("fw_pre", ALUResultM, 32'h20);
    op(3'b000, 32'h1111, 32'h2222);
    ResultW = 32'h30;
    ForwardAE = 2'b10;
    ForwardBE = 2'b01;
    tick();
    chk("fw_alu", ALUResultM, 32'h50);
    chk("fw_wd", WriteDataM, 32'h30);
    op(3'b000, 32'd1, 32'd2);
    ForwardAE = 2'b11;
    ForwardBE = 2'b11;
    tick();
    chk("fw_11", ALUResultM, 32'd3);

    // immediate bypasses forwarded B
    op(3'b000, 32'd10, 32'd99);
    ALUSrcE = 1'b1;
    ForwardBE = 2'b01;
    ImmExtE = 32'd4;
    ResultW = 32'h30;
    tick();
    chk("imm_alu", ALUResultM, 32'd14);
    chk("imm_wd", WriteDataM, 32'h30);

    // slt, logic, wrap
    op(3'b101, 32'hFFFF_FFFF, 32'd1);
    tick();
    chk("slt_neg", ALUResultM, 32'd1);
    op(3'b101, 32'd1, 32'hFFFF_FFFF);
    tick();
    chk("slt_pos", ALUResultM, 32'd0);
    op(3'b010, 32'hF0F0, 32'h0FF0);
    tick();
    chk("and", ALUResultM, 32'h00F0);
    op(3'b011, 32'hF0F0, 32'h0FF0);
    tick();
    chk("or", ALUResultM, 32'hFFF0);
    op(3'b000, 32'hFFFF_FFFF, 32'd1);
    BranchE = 1'b1;
    #1;
    chk("wrap_zero", {31'd0, PCSrcE}, 32'd1);
    tick();
    chk("wrap_add", ALUResultM, 32'd0);
    op(3'b001, 32'd0, 32'd1);
    tick();
    chk("sub_wrap", ALUResultM, 32'hFFFF_FFFF);
    op(3'b111, 32'h1234, 32'h5678);
    tick();
    chk("undef_op", ALUResultM, 32'd0);

    // bubble passes through as zero control
    op(3'b000, 32'd0, 32'd0);
    RegWriteE = 1'b0;
    RDE = 5'd0;
    tick();
    chk("bubble_rw", {31'd0, RegWriteM}, 32'd0);

    // back-to-back with mid-stream reset
    op(3'b000, 32'd1, 32'd2);
    RegWriteE = 1'b1;
    RDE = 5'd5;
    tick();
    chk("b2b_a", ALUResultM, 32'd3);
    op(3'b000, 32'd4, 32'd4);
    RDE = 5'd6;
    MemWriteE = 1'b1;
    ResultSrcE = 1'b1;
    PCPlus4E = 32'h208;
    #2 rst = 1'b0;
    #1;
    zero_m("mid_rst");
    #1 rst = 1'b1;
    tick();
    chk("b2b_alu", ALUResultM, 32'd8);
    chk("b2b_rd", {27'd0, RDM}, 32'd6);
    chk("b2b_mw", {31'd0, MemWriteM}, 32'd1);
    chk("b2b_rs", {31'd0, ResultSrcM}, 32'd1);
    chk("b2b_pc4", PCPlus4M, 32'h208);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the five-stage RISC-V pipeline: receives the decoded control, register operands and immediate from the Decode stage (the E-suffixed bundle), resolves operand forwarding, performs the ALU operation and branch resolution, and registers the result bundle toward the Memory stage. Branch outcome (PCSrcE, PCTargetE) is returned combinationally to Fetch; the ALU result is fed back as a forwarding source.

## Interface
- No parameters; datapath fixed at 32 bits, register index 5 bits.
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE  in  1 each  control from Decode.
- ALUControlE  in  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 101 slt (signed); others give 0.
- RD1E, RD2E  in  32  register-file operands.
- ImmExtE, PCE, PCPlus4E  in  32  sign-extended immediate, PC, PC+4.
- RDE  in  5  destination register.
- ResultW  in  32  Writeback result (forwarding source).
- ForwardAE, ForwardBE  in  2  forward select from hazard unit: 00 RD1E/RD2E, 01 ResultW, 10 ALUResultM, 11 treated as 00.
- PCSrcE  out  1  taken branch = BranchE & Zero (combinational).
- PCTargetE  out  32  PCE + ImmExtE, mod 2^32 (combinational).
- RegWriteM, MemWriteM, ResultSrcM  out  1 each  registered control.
- ALUResultM, WriteDataM, PCPlus4M  out  32  registered datapath.
- RDM  out  5  registered destination.

## Operation
- SrcAE = mux(ForwardAE; RD1E, ResultW, ALUResultM).
- WriteDataE = mux(ForwardBE; RD2E, ResultW, ALUResultM).
- SrcBE = ALUSrcE ? ImmExtE : WriteDataE (immediate bypasses forwarding).
- ALU: add/sub wrap mod 2^32, no overflow flag; slt = signed compare, result 32'd1 or 32'd0; Zero = (ALUResult == 0).
- Branch: only BEQ semantics (Decode issues sub); PCSrcE = BranchE & Zero.
- E/M register captures RegWriteE, MemWriteE, ResultSrcE, RDE, PCPlus4E, WriteDataE, ALUResult every rising edge; no stall, no enable.
- Flushing is done upstream (Decode clears its E register); a bubble arrives as all-zero control and is passed through unchanged.
- ALUResultM forwarding uses the register output, i.e. value of the previous instruction.

## Timing
- Combinational: SrcA/SrcB, ALU, Zero, PCSrcE, PCTargetE valid same cycle as E inputs.
- Latency E inputs -> M outputs: exactly 1 cycle.
- Throughput: one instruction per cycle.
- Reset (rst=0): all M outputs go to 0 immediately, asynchronously; held while low; first capture on first rising edge after rst=1.
- Reset mid-operation: in-flight M bundle discarded (reads 0), no partial update.
- Combinational outputs are not reset; they track inputs (all-zero control during reset gives PCSrcE=0).
- Forward select 01 and 10 both valid same cycle on A and B independently.

## Structure
- Shared package: ALU op encodings (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT), forward-select encodings (FWD_RD, FWD_W, FWD_M), data width 32 and register index width 5; Decode and hazard unit import the same constants.
- One sub-module: alu (SrcA, SrcB, ALUControl -> ALUResult, Zero), purely combinational.
- execute_stage holds the forwarding muxes, branch adder and E/M register.

## Test plan
- Reset: rst=0 with random E inputs -> all M outputs 0 asynchronously; rst=1, RD1E=5, RD2E=7, add, RegWriteE=1, RDE=3 -> next edge ALUResultM=12, RDM=3, RegWriteM=1.
- Branch: RD1E=RD2E=9, sub, BranchE=1, PCE=0x100, ImmExtE=0xFFFFFFF0 -> PCSrcE=1, PCTargetE=0xF0 same cycle; RD2E=8 -> PCSrcE=0.
- Forwarding: ALUResultM=0x20, ResultW=0x30, ForwardAE=10, ForwardBE=01, add -> ALUResultM=0x50 next edge, WriteDataM=0x30.
- Immediate: ALUSrcE=1, ForwardBE=01, ImmExtE=4, RD1E=10, add -> ALUResultM=14, WriteDataM=ResultW.
- slt/logic/wrap: SrcA=0xFFFFFFFF, SrcB=1, slt -> 1; and/or on 0xF0F0/0x0FF0 -> 0x00F0/0xFFF0; add 0xFFFFFFFF+1 -> 0, Zero=1.
- Back-to-back with mid-stream rst pulse between edges -> M outputs 0 immediately, pipeline resumes with next instruction's values one edge after release.
